// File: rtl/ctrl_pkg.sv
// Shared opcode, ALU-code and FSM-state definitions for the execute-stage control.
package ctrl_pkg;

  localparam logic [4:0] OP_ALU  = 5'b00000;
  localparam logic [4:0] OP_J    = 5'b00001;
  localparam logic [4:0] OP_BNE  = 5'b00010;
  localparam logic [4:0] OP_JAL  = 5'b00011;
  localparam logic [4:0] OP_JR   = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_BLT  = 5'b00110;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_ADDX = 5'b10001;
  localparam logic [4:0] OP_SETX = 5'b10101;
  localparam logic [4:0] OP_BEX  = 5'b10110;
  localparam logic [4:0] OP_TTY  = 5'b11110;

  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SUB  = 5'b00001;
  localparam logic [4:0] ALU_MULT = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/ctrl_decode.sv
// Purely combinational primary-opcode decoder; reusable by any pipeline stage.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [31:0]       instruction,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] status,
  output logic [4:0]        alu_opcode_c,
  output logic [4:0]        shamt_c,
  output logic [DATA_W-1:0] imm_c,
  output logic [DATA_W-1:0] jimm_c,
  output logic              i_c,
  output logic              j_c,
  output logic              jr_c,
  output logic              tty_c,
  output logic              setx_c,
  output logic              md_op_c,
  output logic              md_is_div_c
);

  logic [4:0] op;
  logic       bex_c;
  logic       unused_pc_c;

  assign op          = instruction[31:27];
  assign unused_pc_c = ^pc[26:0];

  always_comb begin
    alu_opcode_c = instruction[6:2];
    i_c          = 1'b0;
    case (op)
      OP_ADDI, OP_SW, OP_LW, OP_ADDX, OP_TTY: begin
        alu_opcode_c = ALU_ADD;
        i_c          = 1'b1;
      end
      OP_BNE, OP_BLT: alu_opcode_c = ALU_SUB;
      default: ;
    endcase
  end

  // bex is taken only for a non-zero, non-negative status word
  assign bex_c       = (op == OP_BEX) & (|status) & ~status[DATA_W-1];
  assign j_c         = (op == OP_J) | (op == OP_JAL) | (op == OP_JR) | bex_c;
  assign jr_c        = (op == OP_JR);
  assign tty_c       = (op == OP_TTY);
  assign setx_c      = (op == OP_SETX);
  assign shamt_c     = instruction[11:7];
  assign imm_c       = {{(DATA_W-17){instruction[16]}}, instruction[16:0]};
  assign jimm_c      = {pc[DATA_W-1:27], instruction[26:0]};
  assign md_op_c     = (op == OP_ALU) & (instruction[6:3] == ALU_MULT[4:1]);
  assign md_is_div_c = (instruction[6:2] == ALU_DIV);

endmodule

// File: rtl/control_execute_seq.sv
// Execute-stage control: registered decode plus multdiv start/ready sequencing
// with pipeline stall and a BUSY-cycle timeout watchdog.
module control_execute_seq
  import ctrl_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MD_TIMEOUT = 64,
  parameter int unsigned CNT_W      = $clog2(MD_TIMEOUT + 1)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [31:0]       instruction,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] status,
  input  logic              md_ready,
  input  logic              md_exception,
  output logic              stall_out,
  output logic              md_start,
  output logic              md_is_div,
  output logic              out_valid,
  output logic [4:0]        ALU_opcode,
  output logic [4:0]        ctrl_shamt,
  output logic [DATA_W-1:0] immediate_value,
  output logic [DATA_W-1:0] jump_immediate_value,
  output logic              i_signal,
  output logic              j_signal,
  output logic              jr_signal,
  output logic              tty_signal,
  output logic              setx_signal,
  output logic              md_done,
  output logic              md_err
);

  logic [4:0]        dec_alu_c, dec_shamt_c;
  logic [DATA_W-1:0] dec_imm_c, dec_jimm_c;
  logic              dec_i_c, dec_j_c, dec_jr_c, dec_tty_c, dec_setx_c;
  logic              dec_md_op_c, dec_is_div_c;
  logic              accept_c;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              md_start_q, md_start_d, md_is_div_q, md_is_div_d;
  logic              out_valid_q, out_valid_d, md_done_q, md_done_d, md_err_q, md_err_d;
  logic [4:0]        alu_q, alu_d, shamt_q, shamt_d;
  logic [DATA_W-1:0] imm_q, imm_d, jimm_q, jimm_d;
  logic              i_q, i_d, j_q, j_d, jr_q, jr_d, tty_q, tty_d, setx_q, setx_d;

  ctrl_decode #(.DATA_W(DATA_W)) u_decode (
    .instruction  (instruction),
    .pc           (pc),
    .status       (status),
    .alu_opcode_c (dec_alu_c),
    .shamt_c      (dec_shamt_c),
    .imm_c        (dec_imm_c),
    .jimm_c       (dec_jimm_c),
    .i_c          (dec_i_c),
    .j_c          (dec_j_c),
    .jr_c         (dec_jr_c),
    .tty_c        (dec_tty_c),
    .setx_c       (dec_setx_c),
    .md_op_c      (dec_md_op_c),
    .md_is_div_c  (dec_is_div_c)
  );

  assign accept_c  = in_valid & (state_q == IDLE);
  // Stall is forced low while reset is held so every output reads zero
  assign stall_out = reset_n & ((state_q == BUSY) | (accept_c & dec_md_op_c));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    md_start_d  = 1'b0;
    md_is_div_d = md_is_div_q;
    out_valid_d = 1'b0;
    md_done_d   = 1'b0;
    md_err_d    = 1'b0;
    alu_d       = alu_q;
    shamt_d     = shamt_q;
    imm_d       = imm_q;
    jimm_d      = jimm_q;
    i_d         = i_q;
    j_d         = j_q;
    jr_d        = jr_q;
    tty_d       = tty_q;
    setx_d      = setx_q;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          alu_d   = dec_alu_c;
          shamt_d = dec_shamt_c;
          imm_d   = dec_imm_c;
          jimm_d  = dec_jimm_c;
          i_d     = dec_i_c;
          j_d     = dec_j_c;
          jr_d    = dec_jr_c;
          tty_d   = dec_tty_c;
          setx_d  = dec_setx_c;
          if (dec_md_op_c) begin
            md_start_d  = 1'b1;
            md_is_div_d = dec_is_div_c;
            cnt_d       = '0;
            state_d     = BUSY;
          end else begin
            out_valid_d = 1'b1;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Completion priority: ready, then exception, then watchdog expiry
        if (md_ready) begin
          md_done_d   = 1'b1;
          out_valid_d = 1'b1;
          state_d     = IDLE;
        end else if (md_exception || (cnt_q == CNT_W'(MD_TIMEOUT - 1))) begin
          md_err_d    = 1'b1;
          out_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      md_start_q  <= 1'b0;
      md_is_div_q <= 1'b0;
      out_valid_q <= 1'b0;
      md_done_q   <= 1'b0;
      md_err_q    <= 1'b0;
      alu_q       <= '0;
      shamt_q     <= '0;
      imm_q       <= '0;
      jimm_q      <= '0;
      i_q         <= 1'b0;
      j_q         <= 1'b0;
      jr_q        <= 1'b0;
      tty_q       <= 1'b0;
      setx_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      md_start_q  <= md_start_d;
      md_is_div_q <= md_is_div_d;
      out_valid_q <= out_valid_d;
      md_done_q   <= md_done_d;
      md_err_q    <= md_err_d;
      alu_q       <= alu_d;
      shamt_q     <= shamt_d;
      imm_q       <= imm_d;
      jimm_q      <= jimm_d;
      i_q         <= i_d;
      j_q         <= j_d;
      jr_q        <= jr_d;
      tty_q       <= tty_d;
      setx_q      <= setx_d;
    end
  end

  assign md_start             = md_start_q;
  assign md_is_div            = md_is_div_q;
  assign out_valid            = out_valid_q;
  assign md_done              = md_done_q;
  assign md_err               = md_err_q;
  assign ALU_opcode           = alu_q;
  assign ctrl_shamt           = shamt_q;
  assign immediate_value      = imm_q;
  assign jump_immediate_value = jimm_q;
  assign i_signal             = i_q;
  assign j_signal             = j_q;
  assign jr_signal            = jr_q;
  assign tty_signal           = tty_q;
  assign setx_signal          = setx_q;

endmodule

// File: tb/tb_control_execute_seq.sv
// Directed bench for control_execute_seq with a queue scoreboard on out_valid.
module tb_control_execute_seq;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned MD_TIMEOUT = 8;

  logic              clock;
  logic              reset_n;
  logic              in_valid;
  logic [31:0]       instruction;
  logic [DATA_W-1:0] pc;
  logic [DATA_W-1:0] status;
  logic              md_ready;
  logic              md_exception;
  logic              stall_out, md_start, md_is_div, out_valid;
  logic [4:0]        ALU_opcode, ctrl_shamt;
  logic [DATA_W-1:0] immediate_value, jump_immediate_value;
  logic              i_signal, j_signal, jr_signal, tty_signal, setx_signal;
  logic              md_done, md_err;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [4:0]  alu;
    logic [4:0]  shamt;
    logic        i, j, jr, tty, setx, done, err;
    logic [31:0] imm;
    logic [31:0] jimm;
  } exp_t;

  exp_t sb_q[$];

  localparam logic [31:0] PC_V  = 32'hB800_0040;
  localparam logic [31:0] ADDI  = {5'b00101, 5'd1, 5'd2, 17'h1FFFF};
  localparam logic [31:0] BEX   = {5'b10110, 27'h0000ABC};
  localparam logic [31:0] MULT  = {5'b00000, 5'd3, 5'd4, 5'd5, 5'd0, 5'b00110, 2'b00};
  localparam logic [31:0] DIV   = {5'b00000, 5'd6, 5'd7, 5'd8, 5'd0, 5'b00111, 2'b00};
  localparam logic [31:0] ADD9  = {5'b00000, 5'd1, 5'd2, 5'd3, 5'd9, 5'b00000, 2'b00};

  control_execute_seq #(.DATA_W(DATA_W), .MD_TIMEOUT(MD_TIMEOUT)) dut (
    .clock                (clock),
    .reset_n              (reset_n),
    .in_valid             (in_valid),
    .instruction          (instruction),
    .pc                   (pc),
    .status               (status),
    .md_ready             (md_ready),
    .md_exception         (md_exception),
    .stall_out            (stall_out),
    .md_start             (md_start),
    .md_is_div            (md_is_div),
    .out_valid            (out_valid),
    .ALU_opcode           (ALU_opcode),
    .ctrl_shamt           (ctrl_shamt),
    .immediate_value      (immediate_value),
    .jump_immediate_value (jump_immediate_value),
    .i_signal             (i_signal),
    .j_signal             (j_signal),
    .jr_signal            (jr_signal),
    .tty_signal           (tty_signal),
    .setx_signal          (setx_signal),
    .md_done              (md_done),
    .md_err               (md_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference decode written from the opcode table
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] p, input logic [31:0] st);
    exp_t       e;
    logic [4:0] op;
    op     = ins[31:27];
    e      = '0;
    e.alu  = ins[6:2];
    if (op inside {5'd5, 5'd7, 5'd8, 5'd17, 5'd30}) begin
      e.alu = 5'd0;
      e.i   = 1'b1;
    end
    if (op inside {5'd2, 5'd6}) e.alu = 5'd1;
    e.j     = (op inside {5'd1, 5'd3, 5'd4}) || (op == 5'd22 && st != 32'd0 && st[31] == 1'b0);
    e.jr    = (op == 5'd4);
    e.tty   = (op == 5'd30);
    e.setx  = (op == 5'd21);
    e.shamt = ins[11:7];
    e.imm   = {{15{ins[16]}}, ins[16:0]};
    e.jimm  = {p[31:27], ins[26:0]};
    return e;
  endfunction

  task automatic drive(input logic [31:0] ins, input logic [31:0] st, input bit done, input bit err);
    exp_t e;
    instruction = ins;
    status      = st;
    pc          = PC_V;
    in_valid    = 1'b1;
    e           = model(ins, PC_V, st);
    e.done      = done;
    e.err       = err;
    sb_q.push_back(e);
  endtask

  task automatic issue_plain(input logic [31:0] ins, input logic [31:0] st);
    @(negedge clock);
    drive(ins, st, 1'b0, 1'b0);
    #1 chk("stall_plain", 64'(stall_out), 64'(0));
    @(posedge clock);
    #1 in_valid = 1'b0;
  endtask

  always @(negedge clock) begin
    if (reset_n === 1'b1 && out_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_out_valid", 64'(out_valid), 64'(0));
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_ctrl", 64'({ALU_opcode, ctrl_shamt, i_signal, j_signal, jr_signal, tty_signal,
                            setx_signal, md_done, md_err}),
                       64'({e.alu, e.shamt, e.i, e.j, e.jr, e.tty, e.setx, e.done, e.err}));
        chk("sb_imm", 64'(immediate_value), 64'(e.imm));
        chk("sb_jimm", 64'(jump_immediate_value), 64'(e.jimm));
      end
    end
    if (reset_n === 1'b1 && (md_done === 1'b1 || md_err === 1'b1))
      chk("done_err_with_valid", 64'(out_valid), 64'(1));
  end

  initial begin
    int n;
    in_valid     = 1'b0;
    instruction  = '0;
    pc           = '0;
    status       = '0;
    md_ready     = 1'b0;
    md_exception = 1'b0;
    reset_n      = 1'b1;
    #1 reset_n   = 1'b0;
    #11;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_stall", 64'(stall_out), 64'(0));
    chk("rst_md_start", 64'(md_start), 64'(0));
    chk("rst_alu", 64'(ALU_opcode), 64'(0));
    chk("rst_imm", 64'(immediate_value), 64'(0));
    @(negedge clock);
    reset_n = 1'b1;

    // addi with negative immediate, then hold with no accept
    issue_plain(ADDI, 32'd0);
    chk("addi_i", 64'(i_signal), 64'(1));
    chk("addi_imm", 64'(immediate_value), 64'(32'hFFFF_FFFF));
    @(posedge clock); #1;
    chk("hold_out_valid", 64'(out_valid), 64'(0));
    chk("hold_i", 64'(i_signal), 64'(1));

    // bex taken / not taken
    issue_plain(BEX, 32'd5);
    chk("bex_taken", 64'(j_signal), 64'(1));
    issue_plain(BEX, 32'd0);
    chk("bex_zero", 64'(j_signal), 64'(0));
    issue_plain(BEX, 32'h8000_0000);
    chk("bex_neg", 64'(j_signal), 64'(0));

    // multiply completing on BUSY cycle 4
    @(negedge clock);
    drive(MULT, 32'd0, 1'b1, 1'b0);
    #1 chk("mult_stall_accept", 64'(stall_out), 64'(1));
    @(posedge clock); #1 in_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      chk("mult_stall_busy", 64'(stall_out), 64'(1));
      chk("mult_start", 64'(md_start), 64'(k == 1));
      chk("mult_is_div", 64'(md_is_div), 64'(0));
      chk("mult_no_valid", 64'(out_valid), 64'(0));
      if (k == 4) md_ready = 1'b1;
      @(posedge clock); #1;
    end
    md_ready = 1'b0;
    chk("mult_done", 64'(md_done), 64'(1));
    chk("mult_out_valid", 64'(out_valid), 64'(1));
    chk("mult_stall_drop", 64'(stall_out), 64'(0));

    // divide with no ready: watchdog fires 8 edges after BUSY entry
    @(negedge clock);
    drive(DIV, 32'd0, 1'b0, 1'b1);
    @(posedge clock); #1 in_valid = 1'b0;
    chk("div_start", 64'(md_start), 64'(1));
    chk("div_is_div", 64'(md_is_div), 64'(1));
    n = 0;
    while (n < 20 && md_err !== 1'b1) begin
      @(posedge clock); #1;
      n++;
    end
    chk("timeout_latency", 64'(n), 64'(MD_TIMEOUT));
    chk("timeout_no_done", 64'(md_done), 64'(0));
    chk("timeout_stall_drop", 64'(stall_out), 64'(0));

    // ready on the same cycle as the timeout: done wins
    @(negedge clock);
    drive(DIV, 32'd0, 1'b1, 1'b0);
    @(posedge clock); #1 in_valid = 1'b0;
    repeat (MD_TIMEOUT - 1) begin @(posedge clock); #1; end
    md_ready = 1'b1;
    @(posedge clock); #1 md_ready = 1'b0;
    chk("race_done", 64'(md_done), 64'(1));
    chk("race_no_err", 64'(md_err), 64'(0));
    @(posedge clock); #1;
    chk("race_no_late_err", 64'(md_err), 64'(0));

    // exception on BUSY cycle 2 with a new instruction waiting upstream
    @(negedge clock);
    drive(DIV, 32'd0, 1'b0, 1'b1);
    @(posedge clock); #1;
    drive(ADDI, 32'd0, 1'b0, 1'b0);
    @(posedge clock); #1;
    chk("exc_pending_not_accepted", 64'(out_valid), 64'(0));
    chk("exc_stall_busy", 64'(stall_out), 64'(1));
    md_exception = 1'b1;
    @(posedge clock); #1 md_exception = 1'b0;
    chk("exc_err", 64'(md_err), 64'(1));
    chk("exc_no_done", 64'(md_done), 64'(0));
    chk("exc_alu_is_div", 64'(ALU_opcode), 64'(5'b00111));
    chk("exc_stall_release", 64'(stall_out), 64'(0));
    @(posedge clock); #1 in_valid = 1'b0;
    chk("exc_pending_accepted", 64'(out_valid), 64'(1));
    chk("exc_pending_alu", 64'(ALU_opcode), 64'(0));

    // ready pulse outside BUSY is ignored
    @(negedge clock); md_ready = 1'b1;
    @(posedge clock); #1 md_ready = 1'b0;
    chk("idle_ready_no_done", 64'(md_done), 64'(0));
    chk("idle_ready_no_valid", 64'(out_valid), 64'(0));

    // asynchronous reset in the middle of BUSY
    @(negedge clock);
    drive(MULT, 32'd0, 1'b0, 1'b0);
    @(posedge clock); #1 in_valid = 1'b0;
    #2;
    chk("pre_rst_start", 64'(md_start), 64'(1));
    reset_n = 1'b0;
    #1;
    sb_q.delete();
    chk("arst_md_start", 64'(md_start), 64'(0));
    chk("arst_stall", 64'(stall_out), 64'(0));
    chk("arst_alu", 64'(ALU_opcode), 64'(0));
    chk("arst_is_div", 64'(md_is_div), 64'(0));
    repeat (2) begin
      @(posedge clock); #1;
      chk("arst_no_pulse", 64'({md_done, md_err, out_valid}), 64'(0));
    end
    @(negedge clock); reset_n = 1'b1;
    issue_plain(ADD9, 32'd0);
    chk("post_rst_valid", 64'(out_valid), 64'(1));
    chk("post_rst_shamt", 64'(ctrl_shamt), 64'(9));

    repeat (3) @(negedge clock);
    chk("sb_drained", 64'(sb_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
